tdm_capture_arb: RTL and testbench

TDM_CAPTURE_ARB -- requirements
Module: tdm_capture_arb

---
 rtl/data_capture_pkg.sv | 14 +
 rtl/capture_fifo.sv | 55 +++++
 rtl/tdm_capture_arb.sv | 137 +++++++++++++
 tb/tb_tdm_capture_arb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_capture_pkg.sv
// Shared defaults and arbiter state type for the TDM capture arbiter.
package data_capture_pkg;

    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 8;

    // IDLE: output register empty. HOLD: output register holds a word.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/capture_fifo.sv
// Per-channel synchronous FIFO with first-word fall-through read data.
// Pointers carry one extra MSB so that full and empty can be told apart.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module capture_fifo
    import data_capture_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    assign dout     = mem_q[rd_ptr_q[AW-1:0]];

    // Storage write; when full with a simultaneous pop, the slot being read out is reused.
    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/tdm_capture_arb.sv
// TDM capture arbiter: per-channel FIFOs merged round-robin into one
// registered output with a valid/ready handshake.
// Optional sticky overflow flags are built when DATA_CAPTURE_OVF_EN is defined;
// otherwise o_overflow is tied low and i_ovf_clear is ignored.
module tdm_capture_arb
    import data_capture_pkg::*;
#(
    parameter int  NUM_CH     = DEF_NUM_CH,
    parameter int  DATA_W     = DEF_DATA_W,
    parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                     i_ss_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH*DATA_W-1:0] i_din,
    input  logic [NUM_CH-1:0]        i_din_valid,
    output logic [DATA_W-1:0]        o_dout,
    output logic [CH_W-1:0]          o_dout_ch,
    output logic                     o_dout_valid,
    input  logic                     i_dout_ready,
    output logic [NUM_CH-1:0]        o_full,
    output logic [NUM_CH-1:0]        o_overflow,
    input  logic                     i_ovf_clear
);

    logic [NUM_CH-1:0] fifo_full, fifo_empty, fifo_pop;
    logic [DATA_W-1:0] fifo_dout [NUM_CH];

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   last_q;
    logic [CH_W-1:0]   grant;
    logic              grant_vld;
    logic              xfer, load;
    logic [DATA_W-1:0] dout_q;
    logic [CH_W-1:0]   dout_ch_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        capture_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i (i_ss_clk),
            .rst_i (i_rst),
            .push  (i_din_valid[c]),
            .pop   (fifo_pop[c]),
            .din   (i_din[c*DATA_W +: DATA_W]),
            .dout  (fifo_dout[c]),
            .full  (fifo_full[c]),
            .empty (fifo_empty[c])
        );
    end

    assign o_full       = fifo_full;
    assign o_dout       = dout_q;
    assign o_dout_ch    = dout_ch_q;
    assign o_dout_valid = (state_q == ARB_HOLD);

    // Round-robin search from last_q+1; scanning farthest-first lets the nearest non-empty channel win.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = last_q;
        grant_vld = 1'b0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(last_q) + i) % NUM_CH;
            if (!fifo_empty[idx]) begin
                grant     = CH_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    // Arbiter next-state, transfer/load decode and FIFO pop.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        fifo_pop = '0;
        xfer     = (state_q == ARB_HOLD) && i_dout_ready;
        load     = ((state_q == ARB_IDLE) || xfer) && grant_vld;
        case (state_q)
            ARB_IDLE: if (load)          state_d = ARB_HOLD;
            ARB_HOLD: if (xfer && !load) state_d = ARB_IDLE;
            default:                     state_d = ARB_IDLE;
        endcase
        if (load) begin
            fifo_pop[grant] = 1'b1;
        end
    end

    // Arbiter state register.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_ss_clk) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word register and round-robin pointer, loaded together with the grant.
    always_ff @(posedge i_ss_clk) begin
        if (i_rst) begin
            dout_q    <= '0;
            dout_ch_q <= '0;
            last_q    <= CH_W'(NUM_CH - 1);
        end else if (load) begin
            dout_q    <= fifo_dout[grant];
            dout_ch_q <= grant;
            last_q    <= grant;
        end
    end

`ifdef DATA_CAPTURE_OVF_EN
    logic [NUM_CH-1:0] ovf_q, ovf_d, drop;

    // A word is dropped when its FIFO is full and not being drained this edge.
    assign drop  = i_din_valid & fifo_full & ~fifo_pop;
    assign ovf_d = (i_ovf_clear ? '0 : ovf_q) | drop;

    // Sticky overflow flags; a drop coinciding with a clear leaves the bit set.
    always_ff @(posedge i_ss_clk) begin
        if (i_rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_overflow = ovf_q;
`else
    logic unused_ovf_clear;

    assign unused_ovf_clear = i_ovf_clear;
    assign o_overflow       = '0;
`endif

endmodule

// File: tb/tb_tdm_capture_arb.sv
// Self-checking bench for tdm_capture_arb with a queue-based reference model
// and a scoreboard monitor. Honours DATA_CAPTURE_OVF_EN like the design.
module tb_tdm_capture_arb;
    import data_capture_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CH_W   = $clog2(NUM_CH);
`ifdef DATA_CAPTURE_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } word_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] din;
    logic [NUM_CH-1:0]        din_valid;
    logic                     ready;
    logic                     ovf_clear;
    logic [DATA_W-1:0]        dout;
    logic [CH_W-1:0]          dout_ch;
    logic                     dout_valid;
    logic [NUM_CH-1:0]        full;
    logic [NUM_CH-1:0]        ovf;

    always #5 clk = ~clk;

    tdm_capture_arb #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_ss_clk     (clk),
        .i_rst        (rst),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .o_dout       (dout),
        .o_dout_ch    (dout_ch),
        .o_dout_valid (dout_valid),
        .i_dout_ready (ready),
        .o_full       (full),
        .o_overflow   (ovf),
        .i_ovf_clear  (ovf_clear)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: one queue per channel, the output slot, the round-robin
    // pointer and the overflow flags. exp_q is the scoreboard of words to be delivered.
    logic [DATA_W-1:0] mq [NUM_CH][$];
    bit                m_valid = 1'b0;
    int                m_last  = NUM_CH - 1;
    logic [NUM_CH-1:0] m_ovf   = '0;
    word_t             exp_q[$];
    word_t             seen_q[$];

    initial begin : model
        int    popped;
        int    c;
        word_t w;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < NUM_CH; k++) mq[k].delete();
                m_valid = 1'b0;
                m_last  = NUM_CH - 1;
                m_ovf   = '0;
                exp_q.delete();
            end else begin
                popped = -1;
                if (m_valid && ready) m_valid = 1'b0;
                if (!m_valid) begin
                    for (int i = 1; i <= NUM_CH; i++) begin
                        c = (m_last + i) % NUM_CH;
                        if (popped < 0 && mq[c].size() > 0) popped = c;
                    end
                    if (popped >= 0) begin
                        w.ch   = CH_W'(popped);
                        w.data = mq[popped].pop_front();
                        exp_q.push_back(w);
                        m_valid = 1'b1;
                        m_last  = popped;
                    end
                end
                if (OVF_ON && ovf_clear) m_ovf = '0;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (din_valid[k]) begin
                        if (mq[k].size() < DEPTH) mq[k].push_back(din[k*DATA_W +: DATA_W]);
                        else if (OVF_ON)          m_ovf[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: per-cycle status checks, stall stability, and scoreboard pop on transfer.
    initial begin : monitor
        bit                stalled;
        logic [DATA_W-1:0] held_d;
        logic [CH_W-1:0]   held_c;
        word_t             w;
        stalled = 1'b0;
        held_d  = '0;
        held_c  = '0;
        forever begin
            @(negedge clk);
            check("dout_valid", 32'(dout_valid), 32'(m_valid));
            for (int k = 0; k < NUM_CH; k++) begin
                check($sformatf("full[%0d]", k), 32'(full[k]), 32'(mq[k].size() == DEPTH));
                check($sformatf("overflow[%0d]", k), 32'(ovf[k]), 32'(m_ovf[k]));
            end
            if (stalled) begin
                check("stall_valid", 32'(dout_valid), 32'd1);
                check("stall_data", 32'(dout), 32'(held_d));
                check("stall_ch", 32'(dout_ch), 32'(held_c));
            end
            stalled = 1'b0;
            if (dout_valid && !rst) begin
                if (ready) begin
                    check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        check("xfer_data", 32'(dout), 32'(w.data));
                        check("xfer_ch", 32'(dout_ch), 32'(w.ch));
                        w.data = dout;
                        w.ch   = dout_ch;
                        seen_q.push_back(w);
                    end
                end else begin
                    stalled = 1'b1;
                    held_d  = dout;
                    held_c  = dout_ch;
                end
            end
        end
    end

    // Apply one cycle of stimulus, return just after the consuming edge.
    task automatic drive(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DATA_W-1:0] d,
                         input logic r, input logic clr);
        din_valid = v;
        din       = d;
        ready     = r;
        ovf_clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) drive(2'b11, 16'($urandom), 1'b1, 1'b1);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, 1'b1, 1'b0);
    endtask

    initial begin : stimulus
        logic [DATA_W-1:0] exp035 [8];
        exp035 = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
        rst = 1'b1; din = '0; din_valid = '0; ready = 1'b0; ovf_clear = 1'b0;

        // Reset held two cycles with both strobes active.
        do_reset(2);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // Single word on ch1: presented after the second edge, for one cycle.
        drive(2'b10, {8'hA5, 8'h00}, 1'b1, 1'b0);
        drive('0, '0, 1'b1, 1'b0);
        check("single_valid", 32'(dout_valid), 32'd1);
        check("single_data", 32'(dout), 32'hA5);
        check("single_ch", 32'(dout_ch), 32'd1);
        drive('0, '0, 1'b1, 1'b0);
        check("single_gone", 32'(dout_valid), 32'd0);

        // Two channels written together interleave round-robin.
        do_reset(1);
        seen_q.delete();
        for (int i = 0; i < 4; i++) drive(2'b11, {8'(8'h20 + i), 8'(8'h10 + i)}, 1'b1, 1'b0);
        idle(10);
        check("rr_count", 32'(seen_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < seen_q.size(); i++) begin
            check($sformatf("rr_word%0d", i), 32'(seen_q[i].data), 32'(exp035[i]));
        end

        // Fill ch0 with ready low: one word sits in the output register, eight fill the FIFO.
        do_reset(1);
        seen_q.delete();
        for (int i = 0; i < 10; i++) begin
            drive(2'b01, {8'h00, 8'(8'h30 + i)}, 1'b0, 1'b0);
            if (i == 8) begin
                check("fill_full", 32'(full[0]), 32'd1);
                check("fill_no_ovf", 32'(ovf[0]), 32'd0);
            end
        end
        check("drop_ovf", 32'(ovf[0]), 32'(OVF_ON));
        drive(2'b01, {8'h00, 8'h3A}, 1'b0, 1'b1);
        check("clear_with_drop", 32'(ovf[0]), 32'(OVF_ON));
        drive('0, '0, 1'b0, 1'b1);
        check("clear_alone", 32'(ovf[0]), 32'd0);
        idle(14);
        check("drain_count", 32'(seen_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < seen_q.size(); i++) begin
            check($sformatf("drain_word%0d", i), 32'(seen_q[i].data), 32'(8'h30 + i));
        end

        // Ready toggling every cycle during a stream.
        do_reset(1);
        for (int i = 0; i < 24; i++) drive(2'($urandom), 16'($urandom), 1'(i % 2), 1'b0);
        idle(30);

        // Randomised traffic with stall bursts, occasional clears and resets.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            drive(2'($urandom), 16'($urandom),
                  (i % 64 < 24) ? 1'($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0));
        end
        rst = 1'b0;
        idle(40);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
